sync_queue: RTL and testbench

- Synchronous FIFO queue that sits directly downstream of the read-control stage.
- Accepts write requests from the producer and supplies entries on `rd_en` (`rd_en` = `pop & valid`).
- Exports `empty`, whose inverse drives the read-control `valid` input.
- Provides registered read data, occupancy status and one-cycle error pulses for illegal requests.

---
 rtl/sync_queue_if.sv | 31 +++
 rtl/sync_queue.sv | 102 ++++++++++
 tb/tb_sync_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_queue_if.sv
// Handshake and status bundle between sync_queue and its producer / read-control stage.
// master drives the requests, slave is the queue itself.
interface sync_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_queue.sv
// Synchronous FIFO with registered read data, occupancy flags decoded from the
// registered count, and one-cycle overflow/underflow pulses for rejected requests.
module sync_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    sync_queue_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wp_q, wp_d;
    logic [ADDR_WIDTH:0]   rp_q, rp_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic fullFlag;
    logic emptyFlag;
    logic wrAccept;
    logic rdAccept;

    assign fullFlag  = (count_q == FULL_CNT);
    assign emptyFlag = (count_q == '0);

    // A write into a full queue is still legal when a read frees a slot on the same edge.
    assign rdAccept = bus.rd_en & ~emptyFlag;
    assign wrAccept = bus.wr_en & (~fullFlag | rdAccept);

    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = bus.wr_en & ~wrAccept;
        underflow_d  = bus.rd_en & ~rdAccept;

        if (wrAccept) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (rdAccept) begin
            rp_d         = rp_q + PTR_ONE;
            dout_d       = mem_q[rp_q[ADDR_WIDTH-1:0]];
            dout_valid_d = 1'b1;
        end

        case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are never readable.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem_q[wp_q[ADDR_WIDTH-1:0]] <= bus.din;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.full         = fullFlag;
    assign bus.empty        = emptyFlag;
    assign bus.almost_full  = (count_q >= AF_CNT);
    assign bus.almost_empty = (count_q <= AE_CNT);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_queue.sv
// Directed bench for sync_queue: fill/drain, wrap-around, simultaneous requests,
// asynchronous mid-operation reset and a pop/valid read-control loop.
module tb_sync_queue;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sync_queue_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) qif ();

    sync_queue #(
        .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        qif.wr_en = 1'b0;
        qif.rd_en = 1'b0;
        qif.din   = '0;
        #12;
        total++; if (qif.count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", qif.count); end
        total++; if (qif.empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", qif.empty); end
        total++; if (qif.almost_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_ae: got %b want 1", qif.almost_empty); end
        total++; if (qif.full !== 1'b0 || qif.almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full_af: got %b%b want 00", qif.full, qif.almost_full); end
        total++; if (qif.dout !== 8'h00 || qif.dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dout: got %h/%b want 00/0", qif.dout, qif.dout_valid); end
        total++; if (qif.overflow !== 1'b0 || qif.underflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b%b want 00", qif.overflow, qif.underflow); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            qif.wr_en = 1'b1;
            qif.din   = 8'(i);
            step();
            total++; if (qif.count !== 5'(i)) begin bad++; $display("[TB] FAIL fill_count[%0d]: got %0d want %0d", i, qif.count, i); end
            total++; if (qif.almost_full !== (i >= 14)) begin bad++; $display("[TB] FAIL fill_af[%0d]: got %b want %b", i, qif.almost_full, (i >= 14)); end
            total++; if (qif.full !== (i == 16)) begin bad++; $display("[TB] FAIL fill_full[%0d]: got %b want %b", i, qif.full, (i == 16)); end
            total++; if (qif.empty !== 1'b0 || qif.overflow !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty_ovf[%0d]: got %b%b want 00", i, qif.empty, qif.overflow); end
        end
        qif.din = 8'h11;
        step();
        total++; if (qif.overflow !== 1'b1) begin bad++; $display("[TB] FAIL fill_overflow: got %b want 1", qif.overflow); end
        total++; if (qif.count !== 5'd16) begin bad++; $display("[TB] FAIL fill_count_after_ovf: got %0d want 16", qif.count); end
        qif.wr_en = 1'b0;
        step();
        total++; if (qif.overflow !== 1'b0) begin bad++; $display("[TB] FAIL fill_ovf_pulse: got %b want 0", qif.overflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            qif.rd_en = 1'b1;
            step();
            total++; if (qif.dout !== 8'(i) || qif.dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_data[%0d]: got %h/%b want %h/1", i, qif.dout, qif.dout_valid, 8'(i)); end
            total++; if (qif.count !== 5'(16 - i)) begin bad++; $display("[TB] FAIL drain_count[%0d]: got %0d want %0d", i, qif.count, 16 - i); end
            total++; if (qif.empty !== (i == 16) || qif.almost_empty !== (i >= 14)) begin bad++; $display("[TB] FAIL drain_flags[%0d]: got %b%b want %b%b", i, qif.empty, qif.almost_empty, (i == 16), (i >= 14)); end
        end
        step();
        total++; if (qif.underflow !== 1'b1 || qif.dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_underflow: got %b/%b want 1/0", qif.underflow, qif.dout_valid); end
        total++; if (qif.dout !== 8'h10) begin bad++; $display("[TB] FAIL drain_dout_hold: got %h want 10", qif.dout); end
        qif.rd_en = 1'b0;
        step();
        total++; if (qif.underflow !== 1'b0) begin bad++; $display("[TB] FAIL drain_udf_pulse: got %b want 0", qif.underflow); end
    endtask

    task automatic test_wrap();
        int n [2] = '{10, 12};
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < n[r]; k++) begin
                qif.wr_en = 1'b1;
                qif.din   = 8'(8'h20 + r * 8'h20 + k);
                step();
            end
            qif.wr_en = 1'b0;
            total++; if (qif.count !== 5'(n[r])) begin bad++; $display("[TB] FAIL wrap_count_full[%0d]: got %0d want %0d", r, qif.count, n[r]); end
            for (int k = 0; k < n[r]; k++) begin
                qif.rd_en = 1'b1;
                step();
                total++; if (qif.dout !== 8'(8'h20 + r * 8'h20 + k) || qif.dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_data[%0d][%0d]: got %h want %h", r, k, qif.dout, 8'(8'h20 + r * 8'h20 + k)); end
            end
            qif.rd_en = 1'b0;
            total++; if (qif.count !== 5'd0 || qif.empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_count_zero[%0d]: got %0d/%b want 0/1", r, qif.count, qif.empty); end
        end
        step();
    endtask

    task automatic test_simul_empty();
        qif.wr_en = 1'b1;
        qif.rd_en = 1'b1;
        qif.din   = 8'h77;
        step();
        total++; if (qif.underflow !== 1'b1 || qif.dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL simul_empty_udf: got %b/%b want 1/0", qif.underflow, qif.dout_valid); end
        total++; if (qif.count !== 5'd1) begin bad++; $display("[TB] FAIL simul_empty_count: got %0d want 1", qif.count); end
        qif.wr_en = 1'b0;
        step();
        total++; if (qif.dout !== 8'h77 || qif.underflow !== 1'b0 || qif.count !== 5'd0) begin bad++; $display("[TB] FAIL simul_empty_read: got %h/%b/%0d want 77/0/0", qif.dout, qif.underflow, qif.count); end
        qif.rd_en = 1'b0;
        step();
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) begin
            qif.wr_en = 1'b1;
            qif.din   = 8'(8'h80 + i);
            step();
        end
        qif.rd_en = 1'b1;
        qif.din   = 8'hAA;
        step();
        qif.wr_en = 1'b0;
        total++; if (qif.count !== 5'd16 || qif.full !== 1'b1) begin bad++; $display("[TB] FAIL simul_full_count: got %0d/%b want 16/1", qif.count, qif.full); end
        total++; if (qif.overflow !== 1'b0 || qif.underflow !== 1'b0) begin bad++; $display("[TB] FAIL simul_full_err: got %b%b want 00", qif.overflow, qif.underflow); end
        total++; if (qif.dout !== 8'h80 || qif.dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL simul_full_first: got %h/%b want 80/1", qif.dout, qif.dout_valid); end
        for (int k = 1; k <= 16; k++) begin
            step();
            total++; if (qif.dout !== ((k == 16) ? 8'hAA : 8'(8'h80 + k))) begin bad++; $display("[TB] FAIL simul_full_seq[%0d]: got %h want %h", k, qif.dout, ((k == 16) ? 8'hAA : 8'(8'h80 + k))); end
        end
        qif.rd_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            qif.wr_en = 1'b1;
            qif.din   = 8'(8'h60 + i);
            step();
        end
        qif.wr_en = 1'b0;
        qif.rd_en = 1'b1;
        step();
        qif.rd_en = 1'b0;
        total++; if (qif.count !== 5'd7 || qif.dout !== 8'h60) begin bad++; $display("[TB] FAIL mid_pre: got %0d/%h want 7/60", qif.count, qif.dout); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (qif.count !== 5'd0 || qif.empty !== 1'b1 || qif.almost_empty !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_occ: got %0d/%b/%b want 0/1/1", qif.count, qif.empty, qif.almost_empty); end
        total++; if (qif.dout !== 8'h00 || qif.dout_valid !== 1'b0 || qif.full !== 1'b0 || qif.almost_full !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_out: got %h/%b/%b/%b want 00/0/0/0", qif.dout, qif.dout_valid, qif.full, qif.almost_full); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        qif.wr_en = 1'b1;
        qif.din   = 8'h55;
        step();
        qif.wr_en = 1'b0;
        total++; if (qif.count !== 5'd1) begin bad++; $display("[TB] FAIL mid_post_write: got %0d want 1", qif.count); end
        qif.rd_en = 1'b1;
        step();
        qif.rd_en = 1'b0;
        total++; if (qif.dout !== 8'h55 || qif.dout_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_post_read: got %h/%b want 55/1", qif.dout, qif.dout_valid); end
        step();
    endtask

    task automatic test_read_control();
        int pulses = 0;
        int udfs   = 0;
        logic pop;
        for (int i = 0; i < 5; i++) begin
            qif.wr_en = 1'b1;
            qif.din   = 8'(8'h90 + i);
            step();
        end
        qif.wr_en = 1'b0;
        pop = 1'b1;
        for (int c = 0; c < 10; c++) begin
            qif.rd_en = pop & ~qif.empty;
            step();
            if (qif.dout_valid) begin
                total++; if (qif.dout !== 8'(8'h90 + pulses)) begin bad++; $display("[TB] FAIL rc_data[%0d]: got %h want %h", pulses, qif.dout, 8'(8'h90 + pulses)); end
                pulses++;
            end
            if (qif.underflow) udfs++;
        end
        qif.rd_en = 1'b0;
        total++; if (pulses !== 5) begin bad++; $display("[TB] FAIL rc_pulses: got %0d want 5", pulses); end
        total++; if (udfs !== 0) begin bad++; $display("[TB] FAIL rc_underflow: got %0d want 0", udfs); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul_empty();
        test_simul_full();
        test_reset_mid();
        test_read_control();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
